// File: rtl/apb_multitimer_if.sv
// APB3 completer bus bundle for the multi-channel timer.
// Signal names follow the APB convention so the bus reads naturally at the boundary.
interface apb_multitimer_if;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_multitimer.sv
// Multi-channel APB down-counter timer: per-channel LOAD/VALUE/CTRL/RIS with
// periodic or one-shot reload, optional external count enable, masked interrupts.
module apb_multitimer #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_multitimer_if.slave   apb,
  input  logic [NUM_CH-1:0] timer_clken,
  output logic [NUM_CH-1:0] timer_int,
  output logic              timer_intc
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned CH_W   = 3;

  localparam logic [OFF_W-1:0] OFF_LOAD   = 3'd0;
  localparam logic [OFF_W-1:0] OFF_VALUE  = 3'd1;
  localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd2;
  localparam logic [OFF_W-1:0] OFF_INTCLR = 3'd3;
  localparam logic [OFF_W-1:0] OFF_RIS    = 3'd4;
  localparam logic [OFF_W-1:0] OFF_MIS    = 3'd5;
  localparam logic [OFF_W-1:0] OFF_BGLOAD = 3'd6;

  typedef struct packed {
    logic exten;
    logic inten;
    logic oneshot;
    logic en;
  } ctrl_t;

  logic [CNT_WIDTH-1:0] load_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] load_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] value_q [NUM_CH];
  logic [CNT_WIDTH-1:0] value_d [NUM_CH];
  ctrl_t                ctrl_q  [NUM_CH];
  ctrl_t                ctrl_d  [NUM_CH];
  logic [NUM_CH-1:0]    ris_q;
  logic [NUM_CH-1:0]    ris_d;

  logic [NUM_CH-1:0]    tick;
  logic [NUM_CH-1:0]    ris_set;
  logic [NUM_CH-1:0]    wr_hit;
  logic [NUM_CH-1:0]    inten;

  logic [CH_W-1:0]      ch_idx;
  logic [OFF_W-1:0]     reg_off;
  logic                 ch_space;
  logic                 intstat_hit;
  logic                 wr_en;
  logic [CNT_WIDTH-1:0] wdata_cnt;
  logic [DATA_W-1:0]    rdata_c;
  logic                 unused_bus_bits;

  // Address decode: 0x000-0x0FF is channel space (0x20 per channel), 0x100 is INTSTAT.
  assign ch_idx      = apb.PADDR[7:5];
  assign reg_off     = apb.PADDR[4:2];
  assign ch_space    = (apb.PADDR[11:8] == 4'h0);
  assign intstat_hit = (apb.PADDR[11:2] == 10'h040);
  assign wr_en       = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign wdata_cnt   = apb.PWDATA[CNT_WIDTH-1:0];

  assign unused_bus_bits = ^{apb.PADDR[1:0], apb.PWDATA};

  // Next-state per channel; a LOAD write overrides whatever the tick would have done.
  always_comb begin
    load_d  = load_q;
    value_d = value_q;
    ctrl_d  = ctrl_q;
    ris_d   = ris_q;
    tick    = '0;
    ris_set = '0;
    wr_hit  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tick[c]   = ctrl_q[c].en & (~ctrl_q[c].exten | timer_clken[c]);
      wr_hit[c] = wr_en & ch_space & (ch_idx == CH_W'(c));

      if (tick[c]) begin
        if (value_q[c] > CNT_WIDTH'(1)) begin
          value_d[c] = value_q[c] - CNT_WIDTH'(1);
        end else if (value_q[c] == CNT_WIDTH'(1)) begin
          value_d[c] = '0;
          ris_set[c] = 1'b1;
        end else if (!ctrl_q[c].oneshot) begin
          value_d[c] = load_q[c];
          ris_set[c] = (load_q[c] == '0);
        end
      end

      if (wr_hit[c]) begin
        case (reg_off)
          OFF_LOAD: begin
            load_d[c]  = wdata_cnt;
            value_d[c] = wdata_cnt;
            ris_set[c] = 1'b0;
          end
          OFF_CTRL:   ctrl_d[c] = ctrl_t'(apb.PWDATA[3:0]);
          OFF_BGLOAD: load_d[c] = wdata_cnt;
          default: ;
        endcase
      end

      // A set event in the same cycle as INTCLR wins.
      ris_d[c] = ris_set[c] | (ris_q[c] & ~(wr_hit[c] & (reg_off == OFF_INTCLR)));
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        load_q[c]  <= '0;
        value_q[c] <= '0;
        ctrl_q[c]  <= '0;
      end
      ris_q <= '0;
    end else begin
      load_q  <= load_d;
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      ris_q   <= ris_d;
    end
  end

  always_comb begin
    inten = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      inten[c] = ctrl_q[c].inten;
    end
  end

  assign timer_int  = ris_q & inten;
  assign timer_intc = |timer_int;

  // Read mux is combinational from PADDR so reads complete with zero wait states.
  always_comb begin
    rdata_c = '0;
    if (apb.PSEL && !apb.PWRITE) begin
      if (intstat_hit) begin
        rdata_c = DATA_W'(timer_int);
      end else if (ch_space) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_idx == CH_W'(c)) begin
            case (reg_off)
              OFF_LOAD, OFF_BGLOAD: rdata_c = DATA_W'(load_q[c]);
              OFF_VALUE:            rdata_c = DATA_W'(value_q[c]);
              OFF_CTRL:             rdata_c = DATA_W'(ctrl_q[c]);
              OFF_RIS:              rdata_c = DATA_W'(ris_q[c]);
              OFF_MIS:              rdata_c = DATA_W'(timer_int[c]);
              default:              rdata_c = '0;
            endcase
          end
        end
      end
    end
  end

  assign apb.PRDATA  = rdata_c;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

endmodule

// File: tb/tb_apb_multitimer.sv
// Self-checking bench for apb_multitimer: register reads go through a scoreboard
// queue, expected values are derived by hand from the counter behaviour.
`timescale 1ns/1ps
module tb_apb_multitimer;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned HALF      = 50;

  logic              PCLK    = 1'b0;
  logic              PRESETn = 1'b0;
  logic [NUM_CH-1:0] timer_clken;
  logic [NUM_CH-1:0] timer_int;
  logic              timer_intc;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  apb_multitimer_if apb();

  apb_multitimer #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .apb         (apb),
    .timer_clken (timer_clken),
    .timer_int   (timer_int),
    .timer_intc  (timer_intc)
  );

  always #HALF PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ra(input int ch, input int off);
    return 12'(ch * 32 + off);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK);
      @(negedge PCLK);
    end
  endtask

  // Two-phase APB write; returns on the falling edge after the committing edge.
  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b1;
    apb.PADDR   = a;
    apb.PWDATA  = d;
    @(posedge PCLK);
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] e;
    string       t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = a;
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, apb.PRDATA, e);
    apb.PSEL = 1'b0;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    timer_clken = '0;
    PRESETn     = 1'b0;

    // Reset state
    repeat (2) @(negedge PCLK);
    check("rst_int", 32'(timer_int), 32'h0);
    check("rst_intc", 32'(timer_intc), 32'h0);
    check("pready", 32'(apb.PREADY), 32'h1);
    check("pslverr", 32'(apb.PSLVERR), 32'h0);
    rd_expect("rst_load0", ra(0, 0), 32'h0);
    rd_expect("rst_ctrl2", ra(2, 8), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step(1);

    // Channel 0 periodic with interrupt
    apb_wr(ra(0, 0), 32'd3);
    apb_wr(ra(0, 8), 32'h5);
    rd_expect("c0_v3", ra(0, 4), 32'd3);
    rd_expect("c0_ris_a", ra(0, 16), 32'd0);
    step(1);
    rd_expect("c0_v2", ra(0, 4), 32'd2);
    step(1);
    rd_expect("c0_v1", ra(0, 4), 32'd1);
    rd_expect("c0_ris_b", ra(0, 16), 32'd0);
    step(1);
    rd_expect("c0_v0", ra(0, 4), 32'd0);
    rd_expect("c0_ris_c", ra(0, 16), 32'd1);
    rd_expect("c0_mis", ra(0, 20), 32'd1);
    rd_expect("c0_intstat", 12'h100, 32'h1);
    check("c0_int", 32'(timer_int), 32'h1);
    check("c0_intc", 32'(timer_intc), 32'h1);
    step(1);
    rd_expect("c0_reload", ra(0, 4), 32'd3);
    rd_expect("c0_ris_d", ra(0, 16), 32'd1);
    apb_wr(ra(0, 12), 32'h0);
    rd_expect("c0_v_after_clr", ra(0, 4), 32'd1);
    rd_expect("c0_ris_clr", ra(0, 16), 32'd0);
    check("c0_int_clr", 32'(timer_int), 32'h0);
    apb_wr(ra(0, 8), 32'h0);
    rd_expect("c0_frozen_a", ra(0, 4), 32'd3);
    step(2);
    rd_expect("c0_frozen_b", ra(0, 4), 32'd3);
    rd_expect("c0_ctrl_off", ra(0, 8), 32'h0);
    apb_wr(ra(0, 12), 32'h0);
    rd_expect("c0_ris_clr2", ra(0, 16), 32'd0);

    // Channel 1 one-shot, then interrupt masking
    apb_wr(ra(1, 0), 32'd2);
    apb_wr(ra(1, 8), 32'h7);
    rd_expect("c1_v2", ra(1, 4), 32'd2);
    step(1);
    rd_expect("c1_v1", ra(1, 4), 32'd1);
    step(1);
    rd_expect("c1_v0", ra(1, 4), 32'd0);
    rd_expect("c1_ris", ra(1, 16), 32'd1);
    check("c1_int", 32'(timer_int), 32'h2);
    step(1);
    rd_expect("c1_hold", ra(1, 4), 32'd0);
    apb_wr(ra(1, 8), 32'h3);
    rd_expect("c1_ctrl3", ra(1, 8), 32'h3);
    rd_expect("c1_ris_masked", ra(1, 16), 32'd1);
    rd_expect("c1_mis_masked", ra(1, 20), 32'd0);
    check("c1_int_masked", 32'(timer_int), 32'h0);
    check("c1_intc_masked", 32'(timer_intc), 32'h0);
    apb_wr(ra(1, 12), 32'h0);
    rd_expect("c1_ris_clr", ra(1, 16), 32'd0);
    step(3);
    rd_expect("c1_ris_stays0", ra(1, 16), 32'd0);
    rd_expect("c1_v_stays0", ra(1, 4), 32'd0);
    apb_wr(ra(1, 8), 32'h0);

    // Channel 2 external enable every 4th cycle
    apb_wr(ra(2, 0), 32'd5);
    apb_wr(ra(2, 8), 32'hD);
    rd_expect("c2_v5", ra(2, 4), 32'd5);
    for (int i = 0; i < 20; i++) begin
      timer_clken[2] = ((i % 4) == 3);
      step(1);
      rd_expect($sformatf("c2_val%0d", i), ra(2, 4), 32'(5 - (i + 1) / 4));
    end
    timer_clken = '0;
    rd_expect("c2_ris", ra(2, 16), 32'd1);
    check("c2_int", 32'(timer_int), 32'h4);
    apb_wr(ra(2, 8), 32'h0);
    apb_wr(ra(2, 12), 32'h0);
    rd_expect("c2_ris_clr", ra(2, 16), 32'd0);

    // Channel 3 collisions: INTCLR vs set, LOAD write vs tick, BGLOAD
    apb_wr(ra(3, 0), 32'd3);
    apb_wr(ra(3, 8), 32'h1);
    rd_expect("c3_v3", ra(3, 4), 32'd3);
    step(1);
    rd_expect("c3_v2", ra(3, 4), 32'd2);
    apb_wr(ra(3, 12), 32'h0);
    rd_expect("c3_v0", ra(3, 4), 32'd0);
    rd_expect("c3_set_wins", ra(3, 16), 32'd1);
    check("c3_int_noinen", 32'(timer_int), 32'h0);
    apb_wr(ra(3, 0), 32'd9);
    rd_expect("c3_load_wins", ra(3, 4), 32'd9);
    rd_expect("c3_load9", ra(3, 0), 32'd9);
    step(1);
    rd_expect("c3_v8", ra(3, 4), 32'd8);
    apb_wr(ra(3, 8), 32'h0);
    rd_expect("c3_frozen", ra(3, 4), 32'd6);
    apb_wr(ra(3, 24), 32'h20);
    rd_expect("c3_bg_load", ra(3, 0), 32'h20);
    rd_expect("c3_bg_read", ra(3, 24), 32'h20);
    rd_expect("c3_bg_value", ra(3, 4), 32'd6);
    apb_wr(ra(3, 12), 32'h0);
    rd_expect("c3_ris_clr", ra(3, 16), 32'd0);

    // Width truncation and unmapped space
    apb_wr(ra(0, 0), 32'h0001_2345);
    rd_expect("w_load", ra(0, 0), 32'h0000_2345);
    rd_expect("w_value", ra(0, 4), 32'h0000_2345);
    rd_expect("unmapped_0fc", 12'h0FC, 32'h0);
    apb_wr(ra(4, 0), 32'h55);
    rd_expect("ch4_load", ra(4, 0), 32'h0);
    rd_expect("ch0_untouched", ra(0, 4), 32'h0000_2345);
    rd_expect("intclr_ro", ra(0, 12), 32'h0);
    rd_expect("unmapped_104", 12'h104, 32'h0);
    apb_wr(ra(0, 8), 32'hFFFF_FFF0);
    rd_expect("ctrl_upper", ra(0, 8), 32'h0);
    apb.PSEL   = 1'b0;
    apb.PWRITE = 1'b0;
    apb.PADDR  = ra(0, 0);
    #1;
    check("rd_nosel", apb.PRDATA, 32'h0);

    // Reset mid-count with two interrupts pending
    apb_wr(ra(0, 0), 32'd1);
    apb_wr(ra(1, 0), 32'd1);
    apb_wr(ra(0, 8), 32'h5);
    apb_wr(ra(1, 8), 32'h5);
    step(1);
    check("pre_rst_int", 32'(timer_int), 32'h3);
    check("pre_rst_intc", 32'(timer_intc), 32'h1);
    #10;
    PRESETn = 1'b0;
    #1;
    check("in_rst_int", 32'(timer_int), 32'h0);
    check("in_rst_intc", 32'(timer_intc), 32'h0);
    rd_expect("in_rst_ris0", ra(0, 16), 32'h0);
    rd_expect("in_rst_load1", ra(1, 0), 32'h0);
    step(2);
    PRESETn = 1'b1;
    rd_expect("post_load0", ra(0, 0), 32'h0);
    rd_expect("post_value0", ra(0, 4), 32'h0);
    rd_expect("post_ctrl0", ra(0, 8), 32'h0);
    rd_expect("post_ris1", ra(1, 16), 32'h0);
    rd_expect("post_ctrl1", ra(1, 8), 32'h0);
    step(3);
    rd_expect("post_intstat", 12'h100, 32'h0);
    check("post_int", 32'(timer_int), 32'h0);
    check("post_intc", 32'(timer_intc), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
